// File: rtl/if_stage_pkg.sv
// Shared widths and bus layouts between fetch and decode, plus the sequential-PC helper.
package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 33;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  // Plain 32-bit add: fffffffc wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: decode handshake, branch bus and instruction SRAM port.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_wen;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
           inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
           inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: pre-IF next-PC/SRAM request and IF register with
// a one-entry buffer that holds the returned word while decode stalls.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master fs
);

  br_bus_t     br;
  fs_to_ds_t   out_bus;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  logic        fs_valid_q;
  logic [31:0] fs_pc_q;
  logic        fetch_ret_q;
  logic        inst_buf_valid_q;
  logic [31:0] inst_buf_q;

  assign br = fs.br_bus;

  // Pre-IF: next PC and SRAM request
  assign to_fs_valid = !reset;
  assign seq_pc      = pc_plus4(fs_pc_q);
  assign nextpc      = br.taken ? br.target : seq_pc;

  assign fs.inst_sram_en    = to_fs_valid && fs_allowin;
  assign fs.inst_sram_wen   = 4'h0;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_wdata = 32'h0;

  // IF: handshake towards decode
  assign fs_ready_go       = 1'b1;
  assign fs_allowin        = !fs_valid_q || (fs_ready_go && fs.ds_allowin);
  assign fs.fs_to_ds_valid = fs_valid_q && fs_ready_go;

  assign fs_inst      = inst_buf_valid_q ? inst_buf_q : fs.inst_sram_rdata;
  assign out_bus.inst = fs_inst;
  assign out_bus.pc   = fs_pc_q;
  assign fs.fs_to_ds_bus = out_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      fetch_ret_q      <= 1'b0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      if (fs_allowin) begin
        fs_valid_q <= to_fs_valid;
      end
      if (to_fs_valid && fs_allowin) begin
        fs_pc_q <= nextpc;
      end
      fetch_ret_q <= fs.inst_sram_en;
      // SRAM data is only good in its return cycle; keep it if decode is not taking it.
      if (fetch_ret_q && fs_valid_q && !fs.ds_allowin && !inst_buf_valid_q) begin
        inst_buf_valid_q <= 1'b1;
      end else if (fs.fs_to_ds_valid && fs.ds_allowin) begin
        inst_buf_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_ret_q && fs_valid_q && !fs.ds_allowin && !inst_buf_valid_q) begin
      inst_buf_q <= fs.inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, straight-line fetch, stall buffering,
// delay-slot branches, branch under stall and PC wrap.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] junk_q = 32'h0badf00d;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'hbfc00000)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (bus.master)
  );

  always #5 clk = ~clk;

  // SRAM model: returns the address as data; outside a return cycle it drives junk.
  always @(posedge clk) begin
    junk_q <= junk_q + 32'h01010101;
    bus.inst_sram_rdata <= bus.inst_sram_en ? bus.inst_sram_addr : junk_q;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic ds, input logic taken, input logic [31:0] target);
    @(negedge clk);
    bus.ds_allowin = ds;
    bus.br_bus     = {taken, target};
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {63'd0, bus.fs_to_ds_valid}, 64'd1);
    check({tag, "_pc"},    {32'd0, bus.fs_to_ds_bus[31:0]}, {32'd0, pc});
    check({tag, "_inst"},  {32'd0, bus.fs_to_ds_bus[63:32]}, {32'd0, inst});
  endtask

  task automatic check_req(input string tag, input logic en, input logic [31:0] addr);
    check({tag, "_en"}, {63'd0, bus.inst_sram_en}, {63'd0, en});
    check({tag, "_addr"}, {32'd0, bus.inst_sram_addr}, {32'd0, addr});
  endtask

  initial begin
    reset          = 1'b1;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = '0;

    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_en",    {63'd0, bus.inst_sram_en}, 64'd0);
    check("rst_valid", {63'd0, bus.fs_to_ds_valid}, 64'd0);
    check("rst_pc",    {32'd0, bus.fs_to_ds_bus[31:0]}, 64'h00000000bfbffffc);
    check("wen",       {60'd0, bus.inst_sram_wen}, 64'd0);
    check("wdata",     {32'd0, bus.inst_sram_wdata}, 64'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("c1_valid", {63'd0, bus.fs_to_ds_valid}, 64'd0);
    check_req("c1", 1'b1, 32'hbfc00000);

    // 2. straight line
    step(1'b1, 1'b0, 32'h0);
    check_out("c2", 32'hbfc00000, 32'hbfc00000);
    check_req("c2", 1'b1, 32'hbfc00004);

    // 3. decode stall for 3 cycles
    step(1'b0, 1'b0, 32'h0);
    check_out("s1", 32'hbfc00004, 32'hbfc00004);
    check_req("s1", 1'b0, 32'hbfc00008);
    step(1'b0, 1'b0, 32'h0);
    check_out("s2", 32'hbfc00004, 32'hbfc00004);
    check_req("s2", 1'b0, 32'hbfc00008);
    step(1'b0, 1'b0, 32'h0);
    check_out("s3", 32'hbfc00004, 32'hbfc00004);
    check_req("s3", 1'b0, 32'hbfc00008);
    step(1'b1, 1'b0, 32'h0);
    check_out("rel", 32'hbfc00004, 32'hbfc00004);
    check_req("rel", 1'b1, 32'hbfc00008);

    // 4. taken branch with delay slot in IF
    step(1'b1, 1'b1, 32'hbfc00100);
    check_out("ds", 32'hbfc00008, 32'hbfc00008);
    check_req("br", 1'b1, 32'hbfc00100);
    step(1'b1, 1'b0, 32'h0);
    check_out("tgt", 32'hbfc00100, 32'hbfc00100);
    check_req("tgt", 1'b1, 32'hbfc00104);

    // 5. branch while decode stalls; last br_bus value wins
    step(1'b0, 1'b1, 32'hbfc00200);
    check_out("bs1", 32'hbfc00104, 32'hbfc00104);
    check("bs1_en", {63'd0, bus.inst_sram_en}, 64'd0);
    step(1'b0, 1'b1, 32'hbfc00300);
    check_out("bs2", 32'hbfc00104, 32'hbfc00104);
    check("bs2_en", {63'd0, bus.inst_sram_en}, 64'd0);
    step(1'b1, 1'b1, 32'hbfc00300);
    check_out("bs3", 32'hbfc00104, 32'hbfc00104);
    check_req("bs3", 1'b1, 32'hbfc00300);
    step(1'b1, 1'b0, 32'h0);
    check_out("bs4", 32'hbfc00300, 32'hbfc00300);
    check_req("bs4", 1'b1, 32'hbfc00304);

    // 6. PC wrap
    step(1'b1, 1'b1, 32'hfffffffc);
    check_req("w0", 1'b1, 32'hfffffffc);
    step(1'b1, 1'b0, 32'h0);
    check_out("w1", 32'hfffffffc, 32'hfffffffc);
    check_req("w1", 1'b1, 32'h00000000);
    step(1'b1, 1'b0, 32'h0);
    check_out("w2", 32'h00000000, 32'h00000000);
    check_req("w2", 1'b1, 32'h00000004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
